mem_bus_arbiter: RTL and testbench

Two-master arbiter for the shared 9-bit-address, 16-bit-data memory bus that carries the RAM, the LED register at 9'h100 and the switch port at 9'h140. It sits between the CPU and a second bus master (DMA or debug loader) and the bus decode logic. Per transaction it selects one requester by round-robin, drives the bus command, address and write data, and waits out the synchronous RAM read latency. It returns read data with a one-cycle acknowledge and asserts wait to the stalled master.

---
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus. One transaction at a time:
// latch winner in IDLE, drive it from ISSUE, wait out read latency, pulse ack.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [6:0]        i_m0_cmd,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [6:0]        i_m1_cmd,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m0_wait,
  output logic              o_m1_wait,
  output logic              o_m0_ack,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic [6:0]        o_bus_cmd,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_busy
);

  localparam logic [6:0] M_READ  = 7'b1100000;
  localparam logic [6:0] M_WRITE = 7'b1110000;
  localparam logic [6:0] M_NONE  = 7'b1010000;
  localparam logic [2:0] LAT     = 3'(READ_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StAck} state_e;

  state_e              r_state;
  logic [6:0]          r_bus_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [2:0]          r_lat_cnt;
  logic                r_idx;
  logic                r_last_grant;
  logic                r_ack0;
  logic                r_ack1;

  logic w_v0;
  logic w_v1;
  logic w_grant;

  assign w_v0 = (i_m0_cmd == M_READ) || (i_m0_cmd == M_WRITE);
  assign w_v1 = (i_m1_cmd == M_READ) || (i_m1_cmd == M_WRITE);
  // Contended: the master that did not win last time goes first.
  assign w_grant = (w_v0 && w_v1) ? ~r_last_grant : w_v1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_bus_cmd    <= M_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_lat_cnt    <= '0;
      r_idx        <= 1'b0;
      r_last_grant <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_v0 || w_v1) begin
            r_idx        <= w_grant;
            r_last_grant <= w_grant;
            r_bus_cmd    <= w_grant ? i_m1_cmd : i_m0_cmd;
            r_addr       <= w_grant ? i_m1_addr : i_m0_addr;
            r_wdata      <= w_grant ? i_m1_wdata : i_m0_wdata;
            r_state      <= StIssue;
          end
        end
        StIssue: begin
          if (r_bus_cmd == M_WRITE) begin
            r_bus_cmd <= M_NONE;
            r_ack0    <= ~r_idx;
            r_ack1    <= r_idx;
            r_state   <= StAck;
          end else begin
            r_lat_cnt <= LAT;
            r_state   <= StRdWait;
          end
        end
        StRdWait: begin
          r_lat_cnt <= r_lat_cnt - 3'd1;
          // Read stays on the bus until the capture edge so the read path stays enabled.
          if (r_lat_cnt == 3'd1) begin
            r_rdata   <= i_bus_rdata;
            r_bus_cmd <= M_NONE;
            r_ack0    <= ~r_idx;
            r_ack1    <= r_idx;
            r_state   <= StAck;
          end
        end
        StAck:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_m0_wait   = w_v0 & ~r_ack0;
  assign o_m1_wait   = w_v1 & ~r_ack1;
  assign o_m0_ack    = r_ack0;
  assign o_m1_ack    = r_ack1;
  assign o_rdata     = r_rdata;
  assign o_bus_cmd   = r_bus_cmd;
  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_wdata;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected acks, monitors pop on ack.
// A second instance with READ_LAT=3 checks the longer read latency.
module tb_mem_bus_arbiter;

  localparam logic [6:0] M_READ  = 7'b1100000;
  localparam logic [6:0] M_WRITE = 7'b1110000;
  localparam logic [6:0] M_NONE  = 7'b1010000;

  typedef struct {
    int          m;
    bit          rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [6:0]  m0_cmd = M_NONE, m1_cmd = M_NONE;
  logic [8:0]  m0_addr = '0, m1_addr = '0;
  logic [15:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_wait, m1_wait, ack0, ack1, busy;
  logic [15:0] rdata, bus_wdata, bus_rdata, ram_q;
  logic [6:0]  bus_cmd;
  logic [8:0]  bus_addr;
  logic [15:0] mem [512];

  logic [6:0]  c_m1_cmd = M_NONE;
  logic [8:0]  c_m1_addr = '0;
  logic        c_m0_wait, c_m1_wait, c_ack0, c_ack1, c_busy;
  logic [15:0] c_rdata, c_bus_wdata, c_bus_rdata;
  logic [6:0]  c_bus_cmd;
  logic [8:0]  c_bus_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.ADDR_W(9), .DATA_W(16), .READ_LAT(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_cmd(m0_cmd), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m1_cmd(m1_cmd), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m0_wait(m0_wait), .o_m1_wait(m1_wait), .o_m0_ack(ack0), .o_m1_ack(ack1),
    .o_rdata(rdata), .o_bus_cmd(bus_cmd), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata), .o_busy(busy)
  );

  mem_bus_arbiter #(.ADDR_W(9), .DATA_W(16), .READ_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_cmd(M_NONE), .i_m0_addr(9'h000), .i_m0_wdata(16'h0000),
    .i_m1_cmd(c_m1_cmd), .i_m1_addr(c_m1_addr), .i_m1_wdata(16'h0000),
    .o_m0_wait(c_m0_wait), .o_m1_wait(c_m1_wait), .o_m0_ack(c_ack0), .o_m1_ack(c_ack1),
    .o_rdata(c_rdata), .o_bus_cmd(c_bus_cmd), .o_bus_addr(c_bus_addr),
    .o_bus_wdata(c_bus_wdata), .i_bus_rdata(c_bus_rdata), .o_busy(c_busy)
  );

  // Bus models: synchronous RAM plus switch port at 9'h140 returning 16'h00A5.
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  initial ram_q = '0;
  always @(posedge clk) begin
    if (bus_cmd == M_WRITE) mem[bus_addr] <= bus_wdata;
    ram_q <= mem[bus_addr];
  end
  assign bus_rdata   = (bus_addr == 9'h140) ? 16'h00A5 : ram_q;
  assign c_bus_rdata = (c_bus_addr == 9'h140) ? 16'h00A5 : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit use3, input int m, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = use3 ? c_ack1 : (m != 0 ? ack1 : ack0);
    end
    check("ack_seen", 32'(got), 1);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (ack0 || ack1) begin
      check("ack_pending", 32'(q1.size() > 0), 1);
      check("ack_onehot", 32'(ack0 & ack1), 0);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("ack_master", 32'(ack1), e.m);
        check("ack_cycle", cyc, e.cyc);
        if (e.rd) check("ack_rdata", 32'(rdata), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (c_ack0 || c_ack1) begin
      check("lat3_ack_pending", 32'(q3.size() > 0), 1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check("lat3_ack_master", 32'(c_ack1), e.m);
        check("lat3_ack_cycle", cyc, e.cyc);
        check("lat3_rdata", 32'(c_rdata), 32'(e.data));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int t;
    bit a0, a1;
    // Reset state with both masters idle.
    #12;
    check("rst_bus_cmd", 32'(bus_cmd), 32'(M_NONE));
    check("rst_rdata", 32'(rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_acks", 32'({ack0, ack1}), 0);
    check("rst_waits", 32'({m0_wait, m1_wait}), 0);
    step;
    rst_n = 1'b1;

    // m0 write 9'h005 <- ABCD, then read it back.
    step;
    t = cyc;
    m0_cmd = M_WRITE; m0_addr = 9'h005; m0_wdata = 16'hABCD;
    q1.push_back('{m: 0, rd: 1'b0, data: 16'h0, cyc: t + 2});
    @(negedge clk);
    check("wr_t_bus_none", 32'(bus_cmd), 32'(M_NONE));
    check("wr_t_wait", 32'(m0_wait), 1);
    step;
    @(negedge clk);
    check("wr_t1_bus_cmd", 32'(bus_cmd), 32'(M_WRITE));
    check("wr_t1_addr", 32'(bus_addr), 32'h005);
    check("wr_t1_wdata", 32'(bus_wdata), 32'hABCD);
    wait_ack(1'b0, 0, 4);
    check("wr_ack_wait_low", 32'(m0_wait), 0);
    step;
    t = cyc;
    m0_cmd = M_READ;
    q1.push_back('{m: 0, rd: 1'b1, data: 16'hABCD, cyc: t + 3});
    wait_ack(1'b0, 0, 8);
    step;
    m0_cmd = M_NONE;

    // Fresh reset, then both masters write continuously: m0, m1, m0, m1.
    rst_n = 1'b0;
    #1;
    check("rst2_rdata", 32'(rdata), 0);
    step;
    rst_n = 1'b1;
    step;
    t = cyc;
    m0_cmd = M_WRITE; m0_addr = 9'h010; m0_wdata = 16'h1000;
    m1_cmd = M_WRITE; m1_addr = 9'h020; m1_wdata = 16'h2000;
    q1.push_back('{m: 0, rd: 1'b0, data: 16'h0, cyc: t + 2});
    q1.push_back('{m: 1, rd: 1'b0, data: 16'h0, cyc: t + 5});
    q1.push_back('{m: 0, rd: 1'b0, data: 16'h0, cyc: t + 8});
    q1.push_back('{m: 1, rd: 1'b0, data: 16'h0, cyc: t + 11});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("alt_m0_wait", 32'(m0_wait), 32'(!ack0));
      check("alt_m1_wait", 32'(m1_wait), 32'(!ack1));
      a0 = ack0; a1 = ack1;
      step;
      if (a0) m0_wdata = m0_wdata + 16'd1;
      if (a1) m1_wdata = m1_wdata + 16'd1;
    end
    m0_cmd = M_NONE; m1_cmd = M_NONE;
    check("alt_drained", 32'(q1.size()), 0);

    // m1 reads the switch port, READ_LAT=1.
    step;
    t = cyc;
    m1_cmd = M_READ; m1_addr = 9'h140;
    q1.push_back('{m: 1, rd: 1'b1, data: 16'h00A5, cyc: t + 3});
    wait_ack(1'b0, 1, 8);
    check("sw_m0_ack_quiet", 32'(ack0), 0);
    step;
    m1_cmd = M_NONE;

    // A write must not disturb the captured read data.
    t = cyc;
    m0_cmd = M_WRITE; m0_addr = 9'h006; m0_wdata = 16'h1234;
    q1.push_back('{m: 0, rd: 1'b0, data: 16'h0, cyc: t + 2});
    wait_ack(1'b0, 0, 6);
    check("wr_keeps_rdata", 32'(rdata), 32'h00A5);
    step;
    m0_cmd = M_NONE;

    // Same switch read on the READ_LAT=3 instance.
    step;
    t = cyc;
    c_m1_cmd = M_READ; c_m1_addr = 9'h140;
    q3.push_back('{m: 1, rd: 1'b1, data: 16'h00A5, cyc: t + 5});
    wait_ack(1'b1, 1, 10);
    step;
    c_m1_cmd = M_NONE;

    // Reset during RDWAIT of an m0 read: abandoned, then re-run after release.
    step;
    m0_cmd = M_READ; m0_addr = 9'h005;
    step;
    step;
    #2;
    check("rdw_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rdw_rst_bus_cmd", 32'(bus_cmd), 32'(M_NONE));
    check("rdw_rst_busy", 32'(busy), 0);
    check("rdw_rst_ack", 32'(ack0), 0);
    check("rdw_rst_rdata", 32'(rdata), 0);
    check("rdw_rst_wait", 32'(m0_wait), 1);
    step;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    t = cyc;
    q1.push_back('{m: 0, rd: 1'b1, data: 16'hABCD, cyc: t + 3});
    wait_ack(1'b0, 0, 8);
    step;
    m0_cmd = M_NONE;

    // Invalid encoding is no request.
    step;
    m0_cmd = 7'b0000000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("inv_wait", 32'(m0_wait), 0);
      check("inv_bus_cmd", 32'(bus_cmd), 32'(M_NONE));
      check("inv_busy", 32'(busy), 0);
    end
    step;
    m0_cmd = M_NONE;

    repeat (4) step;
    check("sb_drain", 32'(q1.size()), 0);
    check("sb_drain_lat3", 32'(q3.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
